// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider state encoding and HI/LO source constants
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_e;

  localparam int DIV_W = 32;

  // Signed all-ones so a size cast to any WIDTH still yields {WIDTH{1'b1}}
  localparam logic signed [DIV_W-1:0] DIV_ZERO_QUOT = '1;

  // hi_src/lo_src selector value that routes the divider into HI/LO
  localparam logic [1:0] HILO_SRC_DIV = 2'b10;

endpackage

// File: rtl/div_abs_neg.sv
// rtl/div_abs_neg.sv - conditional two's-complement negate
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en,
  input  logic             unsigned_instr,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             stall
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  div_abs_neg #(.WIDTH(WIDTH)) u_dvd_mag (
    .val_i (dividend),
    .neg_i (~unsigned_instr & dividend[WIDTH-1]),
    .res_o (dvd_mag)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_dvs_mag (
    .val_i (divisor),
    .neg_i (~unsigned_instr & divisor[WIDTH-1]),
    .res_o (dvs_mag)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_quo_fix (
    .val_i (quo_q),
    .neg_i (neg_quo_q),
    .res_o (quo_fix)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_rem_fix (
    .val_i (rem_q),
    .neg_i (neg_rem_q),
    .res_o (rem_fix)
  );

  // Remainder stays below the divisor, so a restored value never needs bit WIDTH
  assign shift_rem = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shift_rem - {1'b0, dvs_q};
  assign rem_d     = trial[WIDTH] ? shift_rem[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_d     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (div_en) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= ~unsigned_instr & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= ~unsigned_instr & dividend[WIDTH-1];
            if (divisor == '0) begin
              // Raw dividend parks in quo_q and becomes the remainder in FIX
              div0_q  <= 1'b1;
              quo_q   <= dividend;
              dvs_q   <= '0;
              state_q <= FIX;
            end else begin
              div0_q  <= 1'b0;
              quo_q   <= dvd_mag;
              dvs_q   <= dvs_mag;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (div0_q) begin
            quotient_q  <= WIDTH'(DIV_ZERO_QUOT);
            remainder_q <= quo_q;
          end else begin
            quotient_q  <= quo_fix;
            remainder_q <= rem_fix;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign stall     = div_en & ~done_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_en;
  logic        unsigned_instr;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        stall;

  iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_en         (div_en),
    .unsigned_instr (unsigned_instr),
    .dividend       (dividend),
    .divisor        (divisor),
    .busy           (busy),
    .done           (done),
    .quotient       (quotient),
    .remainder      (remainder),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference result from plain integer arithmetic
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit u,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (u) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Model: a request taken while idle completes 33 cycles later (1 for divide-by-zero)
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_q    = p_q;
          m_r    = p_r;
        end
      end else if (div_en) begin
        ref_div(dividend, divisor, unsigned_instr, p_q, p_r);
        m_left = (divisor == 32'd0) ? 1 : 33;
      end
    end
  end

  always @(posedge clk) begin
    #3;
    if (chk_en) begin
      check("busy",      32'(busy),      32'(m_left > 0));
      check("done",      32'(done),      32'(m_done));
      check("stall",     32'(stall),     32'(div_en & ~m_done));
      check("quotient",  quotient,       m_q);
      check("remainder", remainder,      m_r);
    end
  end

  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
      if (done) return;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b, input bit u,
                     input logic [31:0] eq, input logic [31:0] er, input int elat);
    int lat, bcyc;
    @(negedge clk);
    div_en = 1'b1; dividend = a; divisor = b; unsigned_instr = u;
    wait_done(lat, bcyc);
    div_en = 1'b0;
    check({name, "_q"},    quotient,   eq);
    check({name, "_r"},    remainder,  er);
    check({name, "_lat"},  32'(lat),   32'(elat));
    check({name, "_busy"}, 32'(bcyc),  32'(elat - 1));
  endtask

  initial begin
    int lat, bcyc;
    rst = 1'b1; div_en = 1'b0; unsigned_instr = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q",    quotient,  32'd0);
    check("rst_r",    remainder, 32'd0);
    rst = 1'b0;

    run("divu_100_7",   32'd100,       32'd7,         1'b1, 32'd14,        32'd2,         34);
    run("div_m7_2",     32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run("divu_m7_2",    32'hFFFF_FFF9, 32'd2,         1'b1, 32'h7FFF_FFFC, 32'd1,         34);
    run("div_ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0,         34);
    run("divu_max_16",  32'hFFFF_FFFF, 32'h10,        1'b1, 32'h0FFF_FFFF, 32'hF,         34);
    run("div_7_m2",     32'd7,         32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 32'd1,         34);
    run("div_5_0",      32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         2);

    // Abort mid-divide: operand change then reset with div_en still high
    @(negedge clk);
    div_en = 1'b1; dividend = 32'd100; divisor = 32'd7; unsigned_instr = 1'b1;
    repeat (5) @(negedge clk);
    dividend = 32'd55; divisor = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q",    quotient,  32'd0);
    check("abort_r",    remainder, 32'd0);
    rst = 1'b0; div_en = 1'b0;
    run("div_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34);

    // Back-to-back with div_en held across done
    @(negedge clk);
    div_en = 1'b1; dividend = 32'd1000; divisor = 32'd10; unsigned_instr = 1'b1;
    wait_done(lat, bcyc);
    check("b2b1_q",     quotient,    32'd100);
    check("b2b1_r",     remainder,   32'd0);
    check("b2b1_stall", 32'(stall),  32'd0);
    dividend = 32'd50; divisor = 32'd7;
    wait_done(lat, bcyc);
    div_en = 1'b0;
    check("b2b2_gap",   32'(lat),    32'd34);
    check("b2b2_q",     quotient,    32'd7);
    check("b2b2_r",     remainder,   32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
